// File: rtl/sha_uart_pkg.sv
// Shared types and constants for the SHA-1 digest to UART byte-stream path.
package sha_uart_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT} state_e;

  localparam int RAW_FRAME_LEN = 20;
  localparam int HEX_FRAME_LEN = 42;

  localparam logic [7:0] ASCII_0    = 8'h30;
  localparam logic [7:0] ASCII_A_LC = 8'h61;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

endpackage

// File: rtl/hex_nibble_to_ascii.sv
// Nibble to lowercase ASCII hex character; purely combinational.
module hex_nibble_to_ascii
  import sha_uart_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [7:0] ascii_o
);

  always_comb begin
    if (nib_i < 4'd10) ascii_o = ASCII_0 + {4'h0, nib_i};
    else               ascii_o = ASCII_A_LC + {4'h0, nib_i} - 8'd10;
  end

endmodule

// File: rtl/sha_digest_uart_tx.sv
// Serialises captured digests MSB-first into UART bytes (raw or hex + CR LF).
// din_vld -> tx_send in 2 cycles; one pending digest is buffered, further ones dropped with overrun.
module sha_digest_uart_tx
  import sha_uart_pkg::*;
#(
  parameter int HEX_MODE = 1,
  parameter int DW       = 160
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din,
  input  logic          din_vld,
  output logic [7:0]    tx_data,
  output logic          tx_send,
  input  logic          tx_done,
  output logic          busy,
  output logic          frame_done,
  output logic          overrun
);

  localparam int FRAME_LEN = (HEX_MODE != 0) ? (DW / 4 + 2) : (DW / 8);
  localparam int SHIFT     = (HEX_MODE != 0) ? 4 : 8;
  localparam logic [5:0] LAST_IDX = 6'(FRAME_LEN - 1);

  state_e        state_q, state_d;
  logic [DW-1:0] pend_q, pend_d;
  logic          pend_vld_q, pend_vld_d;
  logic [DW-1:0] shift_q;
  logic [5:0]    cnt_q;
  logic          busy_q, frame_done_q, overrun_q;
  logic [7:0]    cur_byte;
  logic          last_byte, byte_done, pend_free;

  assign last_byte = (cnt_q == LAST_IDX);
  assign byte_done = (state_q == WAIT) && tx_done;
  // LOAD empties the buffer this cycle, so a simultaneous capture is not an overrun
  assign pend_free = !pend_vld_q || (state_q == LOAD);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (pend_vld_q || din_vld) state_d = LOAD;
      LOAD: state_d = SEND;
      SEND: state_d = WAIT;
      WAIT: if (tx_done) state_d = last_byte ? IDLE : SEND;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q && (state_q != LOAD);
    if (din_vld && pend_free) begin
      pend_d     = din;
      pend_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q       <= '0;
      pend_vld_q   <= 1'b0;
      shift_q      <= '0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      pend_q       <= pend_d;
      pend_vld_q   <= pend_vld_d;
      busy_q       <= (state_d != IDLE) || pend_vld_d;
      frame_done_q <= byte_done && last_byte;
      overrun_q    <= din_vld && !pend_free;
      if (state_q == LOAD) begin
        shift_q <= pend_q;
        cnt_q   <= '0;
      end else if (byte_done && !last_byte) begin
        shift_q <= shift_q << SHIFT;
        cnt_q   <= cnt_q + 6'd1;
      end
    end
  end

  generate
    if (HEX_MODE != 0) begin : g_hex
      localparam logic [5:0] NIB_CNT = 6'(DW / 4);
      logic [7:0] nib_ascii;

      hex_nibble_to_ascii u_nib (
        .nib_i  (shift_q[DW-1 -: 4]),
        .ascii_o(nib_ascii)
      );

      always_comb begin
        if (cnt_q < NIB_CNT)       cur_byte = nib_ascii;
        else if (cnt_q == NIB_CNT) cur_byte = ASCII_CR;
        else                       cur_byte = ASCII_LF;
      end
    end else begin : g_raw
      assign cur_byte = shift_q[DW-1 -: 8];
    end
  endgenerate

  always_comb begin
    tx_send    = (state_q == SEND);
    tx_data    = 8'h00;
    if (state_q == SEND || state_q == WAIT) tx_data = cur_byte;
    busy       = busy_q;
    frame_done = frame_done_q;
    overrun    = overrun_q;
  end

endmodule

// File: doc/sha_digest_uart_tx.md
Name: sha_digest_uart_tx

Overview:
Downstream stage of the UART-fed SHA-1 path. It captures each 160-bit digest on its valid pulse and serialises it MSB-first into a byte stream for the UART byte transmitter. The stream is either raw (20 bytes) or lowercase ASCII hex followed by CR LF (42 bytes). A one-deep pending buffer absorbs a digest that arrives mid-transmission; any further digest is dropped and flagged.

Parameters:
HEX_MODE, 1, 1 = 40 ASCII hex chars + 0x0D 0x0A (42 bytes/frame); 0 = 20 raw bytes/frame
DW, 160, digest width in bits; must be a multiple of 8

Ports:
clk  in  1  system clock; single clock domain
rst  in  1  synchronous, active-high reset
din  in  DW  digest from SHA-1 core
din_vld  in  1  one-cycle pulse; din valid this cycle
tx_data  out  8  byte to UART transmitter; held stable from tx_send until tx_done
tx_send  out  1  one-cycle pulse; starts transmission of tx_data
tx_done  in  1  one-cycle pulse from UART transmitter at end of stop bit
busy  out  1  high while a frame is in flight or a digest is pending
frame_done  out  1  one-cycle pulse after the last byte's tx_done
overrun  out  1  one-cycle pulse when a digest is dropped

Behaviour:
- Reset (synchronous, active-high; takes priority over all inputs):
  - outputs: tx_data=0x00, tx_send=0, busy=0, frame_done=0, overrun=0
  - internal: state=IDLE, pending buffer empty, byte counter=0
  - reset mid-frame aborts the frame immediately; tx_send is not re-issued.
- Capture:
  - din_vld with pending buffer empty: din latched into pending buffer at that edge.
  - din_vld with pending buffer full: din dropped; overrun pulses the next cycle.
- FSM states and transitions:
  - IDLE: pending buffer full -> LOAD.
  - LOAD (1 cycle): pending buffer moved into the shift register; pending buffer cleared; byte counter=0 -> SEND.
  - SEND (1 cycle): tx_send=1 with the current byte on tx_data -> WAIT.
  - WAIT: hold tx_data until tx_done.
    - Not last byte: advance counter/shift -> SEND.
    - Last byte: frame_done=1 for one cycle -> IDLE.
  - tx_done outside WAIT is ignored.
- Capture and load in the same cycle: din_vld in the same cycle as LOAD lands in the freed pending buffer, so no overrun.
- Latency: din_vld at cycle N (FSM in IDLE) -> LOAD at N+1 -> tx_send at N+2.
- Byte order:
  - Raw mode: byte k = din[DW-1-8k -: 8], k = 0..19.
  - Hex mode: char k encodes nibble din[DW-1-4k -: 4], k = 0..39, then 0x0D, 0x0A.
  - Nibble encoding: 0..9 -> 0x30+n; 10..15 -> 0x61+(n-10).
- Counter: 6 bits, terminal value FRAME_LEN-1 (19 or 41); no wrap past terminal.
- busy = (state != IDLE) | pending-buffer-full. Registered; reflects a capture one cycle after din_vld.
- Back-to-back frames: a pending digest causes IDLE -> LOAD on the cycle after frame_done, with no idle gap beyond that cycle.

Decomposition:
- Shared package sha_uart_pkg:
  - FSM state enum {IDLE, LOAD, SEND, WAIT}
  - RAW_FRAME_LEN=20, HEX_FRAME_LEN=42
  - ASCII constants: ASCII_0=0x30, ASCII_A_LC=0x61, ASCII_CR=0x0D, ASCII_LF=0x0A
- One sub-module: hex_nibble_to_ascii (4-bit in, 8-bit out, combinational), instantiated when HEX_MODE=1.

Test Plan:
- Raw mode, din=SHA-1("abc")=a9993e36 4706816a ba3e2571 7850c26c 9cd0d89d; tx model returns tx_done 10 cycles after each tx_send.
  - Exactly 20 tx_send pulses carrying 0xA9, 0x99, ..., 0x9D, in order.
  - tx_send first seen 2 cycles after din_vld; frame_done 1 cycle after the 20th tx_done.
- Hex mode, same digest:
  - 42 bytes: 0x61 ('a'), 0x39 ('9'), 0x39, 0x39, 0x33, ..., 0x64, 0x0D, 0x0A.
  - Nibble 0xF -> 0x66 and 0x0 -> 0x30 both verified (use din=0x0...0F...).
- Second din_vld while byte 5 is in flight:
  - Second digest is sent immediately after the first frame_done; overrun never pulses.
  - busy stays high throughout.
- Third din_vld while the pending buffer is full: overrun pulses once; the third digest is never transmitted.
- rst asserted in WAIT at byte 10:
  - Next cycle tx_send=0, busy=0, pending empty.
  - A fresh din_vld restarts at byte 0.
- Spurious tx_done in IDLE and SEND: ignored; byte counter unchanged; no extra tx_send.
